// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector controller.
package seq_det_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int         CNT_W       = 8;
    localparam logic [3:0] DEF_PATTERN = 4'b1010;

endpackage

// File: rtl/seq_det_core.sv
// Bit-serial pattern matcher: history shift register, fill counter and compare.
module seq_det_core
    import seq_det_pkg::*;
#(
    parameter int PLEN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            bit_valid_i,
    input  logic            bit_i,
    input  logic [PLEN-1:0] pattern_i,
    input  logic            overlap_i,
    output logic            match_o
);

    localparam int            FW   = $clog2(PLEN + 1);
    localparam logic [FW-1:0] FULL = FW'(PLEN);

    logic [PLEN-1:0] hist_q, hist_d, hist_shift;
    logic [FW-1:0]   fill_q, fill_d, fill_inc;

    // A match needs a full window ending on this bit; overlap mode keeps the window full.
    always_comb begin
        hist_shift = {hist_q[PLEN-2:0], bit_i};
        fill_inc   = (fill_q == FULL) ? FULL : fill_q + FW'(1);
        match_o    = bit_valid_i && (hist_shift == pattern_i) && (fill_inc == FULL);
        hist_d     = hist_q;
        fill_d     = fill_q;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bit_valid_i) begin
            hist_d = hist_shift;
            fill_d = (match_o && !overlap_i) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-in, bit-serial pattern detector with match counter and sticky threshold irq.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PLEN  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PLEN-1:0]  cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             irq,
    input  logic             irq_clr,
    output logic             dbg_state
);

    localparam int            BW   = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [PLEN-1:0]  pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             z_q, irq_q, irq_d;
    logic             cfg_load, bit_valid, match, irq_set;

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        bcnt_d    = bcnt_q;
        cfg_load  = 1'b0;
        bit_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_load = cfg_we;
                if (in_valid) begin
                    data_d  = in_data;
                    bcnt_d  = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bit_valid = 1'b1;
                data_d    = data_q << 1;
                bcnt_d    = bcnt_q + BW'(1);
                if (bcnt_q == LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pat_d   = cfg_load ? cfg_pattern : pat_q;
        ovl_d   = cfg_load ? cfg_overlap : ovl_q;
        thr_d   = cfg_load ? cfg_thresh  : thr_q;
        irq_set = match && (cnt_q != '1) && (thr_q != '0) && ((cnt_q + CNT_W'(1)) == thr_q);
        cnt_d   = cnt_q;
        irq_d   = irq_q;
        if (cfg_load) begin
            cnt_d = '0;
            irq_d = 1'b0;
        end else begin
            if (match && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
            if (irq_set)                irq_d = 1'b1;
            else if (irq_clr)           irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            bcnt_q  <= '0;
            pat_q   <= PLEN'(DEF_PATTERN);
            ovl_q   <= 1'b0;
            thr_q   <= '0;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            bcnt_q  <= bcnt_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            thr_q   <= thr_d;
            cnt_q   <= cnt_d;
            z_q     <= match;
            irq_q   <= irq_d;
        end
    end

    seq_det_core #(.PLEN(PLEN)) u_core (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (cfg_load),
        .bit_valid_i (bit_valid),
        .bit_i       (data_q[WIDTH-1]),
        .pattern_i   (pat_q),
        .overlap_i   (ovl_q),
        .match_o     (match)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_SHIFT);
    assign z         = z_q;
    assign match_cnt = cnt_q;
    assign irq       = irq_q;
    assign dbg_state = state_q;

endmodule
